mips_mem_access_unit: RTL

Parametrised load/store unit between the multicycle MIPS core and the Avalon-MM bus master port. It accepts one core memory request at a time and holds address, control and data stable across `waitrequest`. It generates `byteenable` and byte-lane placement for byte, halfword and word accesses, and applies endian conversion and sign/zero extension on loads. It adds a bus timeout with an error response, so a hung slave cannot deadlock the core.

---
 rtl/mips_mem_pkg.sv | 34 +++
 rtl/mem_lane_mux.sv | 63 ++++++
 rtl/mips_mem_access_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS load/store unit: access sizes, FSM states,
// and the byte-count and byte-swap helpers used for lane placement.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } mau_state_t;

  // The core encodes size 3 as a word access.
  function automatic mem_size_t decode_size(input logic [1:0] raw);
    return (raw == 2'd0) ? BYTE : (raw == 2'd1) ? HALF : WORD;
  endfunction

  function automatic logic [2:0] size_bytes(input mem_size_t sz);
    case (sz)
      BYTE:    return 3'd1;
      HALF:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/mem_lane_mux.sv
// Combinational byte-lane steering: store placement with byteenable generation,
// and load extraction with sign/zero extension, for either core endianness.
module mem_lane_mux
  import mips_mem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter bit BIG_ENDIAN = 1'b1,
  localparam int BE_W      = DATA_W / 8,
  localparam int OFF_W     = $clog2(BE_W)
) (
  input  logic [OFF_W-1:0]  off,
  input  mem_size_t         size,
  input  logic              is_unsigned,
  input  logic [31:0]       wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] wlanes,
  output logic [31:0]       rdata_ext
);

  logic [31:0] mask;
  logic [3:0]  be4;
  logic [4:0]  shamt;
  logic [31:0] store_m;
  logic [31:0] load_m;
  logic [31:0] raw;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    mask  = 32'h0000_00FF;
    be4   = 4'b0001;
    shamt = 5'd24;
    case (size)
      HALF: begin
        mask  = 32'h0000_FFFF;
        be4   = 4'b0011;
        shamt = 5'd16;
      end
      WORD: begin
        mask  = 32'hFFFF_FFFF;
        be4   = 4'b1111;
        shamt = 5'd0;
      end
      default: ;
    endcase

    // store_m/load_m hold the accessed bytes in lane order, lowest lane in bits 7:0.
    store_m = BIG_ENDIAN ? bswap32(wdata << shamt) : (wdata & mask);
    wlanes  = DATA_W'(store_m) << {off, 3'b000};
    be      = BE_W'(be4) << off;

    load_m  = 32'(rdata >> {off, 3'b000}) & mask;
    raw     = BIG_ENDIAN ? (bswap32(load_m) >> shamt) : load_m;

    rdata_ext = raw;
    case (size)
      BYTE:    rdata_ext = is_unsigned ? raw : {{24{raw[7]}}, raw[7:0]};
      HALF:    rdata_ext = is_unsigned ? raw : {{16{raw[15]}}, raw[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_mem_access_unit.sv
// Load/store unit between the multicycle MIPS core and an Avalon-MM master port,
// with bus timeout. Define MEM_ALIGN_CHECK_EN to reject misaligned half/word accesses.
module mips_mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter bit BIG_ENDIAN = 1'b1,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  output logic                resp_valid,
  output logic [31:0]         resp_rdata,
  output logic                resp_err,
  output logic [31:0]         address,
  output logic                read,
  output logic                write,
  input  logic                waitrequest,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W-1:0]   readdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  mau_state_t       state;
  logic             q_write;
  logic             q_unsigned;
  mem_size_t        q_size;
  logic [OFF_W-1:0] q_off;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_inc;

  mem_size_t        in_size;
  logic [31:0]      in_addr;
  logic             misaligned;
  logic             accept;
  logic             timeout_hit;

  mem_size_t        mux_size;
  logic [OFF_W-1:0] mux_off;
  logic             mux_unsigned;
  logic [BE_W-1:0]  mux_be;
  logic [DATA_W-1:0] mux_wlanes;
  logic [31:0]      mux_rdata;

  assign in_size = decode_size(req_size);
  assign in_addr = req_addr & ~(32'(size_bytes(in_size)) - 32'd1);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = ((in_size == HALF) && req_addr[0]) ||
                      ((in_size == WORD) && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;

  assign wait_cnt_inc = (wait_cnt == '1) ? wait_cnt : wait_cnt + CNT_W'(1);
  assign timeout_hit  = (TIMEOUT != 0) && (wait_cnt_inc == CNT_LIMIT);

  // One lane mux serves both directions: live request fields place store data at
  // accept, registered fields steer the load data while the bus cycle is open.
  assign mux_size     = (state == IDLE) ? in_size : q_size;
  assign mux_off      = (state == IDLE) ? in_addr[OFF_W-1:0] : q_off;
  assign mux_unsigned = (state == IDLE) ? req_unsigned : q_unsigned;

  mem_lane_mux #(
    .DATA_W     (DATA_W),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_lane_mux (
    .off         (mux_off),
    .size        (mux_size),
    .is_unsigned (mux_unsigned),
    .wdata       (req_wdata),
    .rdata       (readdata),
    .be          (mux_be),
    .wlanes      (mux_wlanes),
    .rdata_ext   (mux_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      q_write    <= 1'b0;
      q_unsigned <= 1'b0;
      q_size     <= BYTE;
      q_off      <= '0;
      wait_cnt   <= '0;
      address    <= '0;
      writedata  <= '0;
      byteenable <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            q_write    <= req_write;
            q_unsigned <= req_unsigned;
            q_size     <= in_size;
            q_off      <= in_addr[OFF_W-1:0];
            if (misaligned) begin
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state      <= RESP;
            end else begin
              address    <= {in_addr[31:OFF_W], {OFF_W{1'b0}}};
              byteenable <= mux_be;
              writedata  <= req_write ? mux_wlanes : '0;
              read       <= !req_write;
              write      <= req_write;
              wait_cnt   <= '0;
              state      <= BUS;
            end
          end
        end
        BUS: begin
          if (!waitrequest) begin
            read       <= 1'b0;
            write      <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= q_write ? '0 : mux_rdata;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt_inc;
            if (timeout_hit) begin
              read       <= 1'b0;
              write      <= 1'b0;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state      <= RESP;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
